// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver feeding a first-word-fall-through receive FIFO.
// Ports: clk/reset (async, active-high), uart_in serial pin, rx_pop head
// removal, clr_err sticky clear; rx_data/rx_valid/rx_count FIFO view,
// rx_interrupt one-cycle push pulse, overrun/frame_err sticky status.
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 25,
    parameter int DEPTH        = 16,
    parameter int PTR_W        = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             uart_in,
    input  logic             rx_pop,
    input  logic             clr_err,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    output logic [PTR_W:0]   rx_count,
    output logic             rx_interrupt,
    output logic             overrun,
    output logic             frame_err
);

    localparam int BC_W = $clog2(CLKS_PER_BIT);
    localparam logic [BC_W-1:0] HALF_LIM = BC_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BC_W-1:0] BIT_LIM  = BC_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state, state_n;
    logic            sync1, rxs;
    logic [BC_W-1:0] bc;
    logic [2:0]      bit_idx;
    logic [7:0]      shreg;
    logic            term, sample, push_req, frame_set;

    logic [7:0]      mem [DEPTH];
    logic [PTR_W:0]  wr_ptr, rd_ptr;
    logic            full, empty, do_pop, push_ok;

    // Two-flop synchronizer; idle-high so reset loads ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            sync1 <= uart_in;
            rxs   <= sync1;
        end
    end

    // START only waits half a bit so later samples land mid-bit.
    assign term = (state == START) ? (bc == HALF_LIM) : (bc == BIT_LIM);

    always_comb begin
        state_n   = state;
        sample    = 1'b0;
        push_req  = 1'b0;
        frame_set = 1'b0;
        unique case (state)
            IDLE: begin
                if (!rxs) state_n = START;
            end
            START: begin
                if (term) state_n = rxs ? IDLE : DATA;
            end
            DATA: begin
                if (term) begin
                    sample = 1'b1;
                    if (bit_idx == 3'd7) state_n = STOP;
                end
            end
            STOP: begin
                if (term) begin
                    state_n = IDLE;
                    if (rxs) push_req  = 1'b1;
                    else     frame_set = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            bc      <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE || state_n != state || term) bc <= '0;
            else bc <= bc + 1'b1;
            if (state == START) bit_idx <= '0;
            else if (sample) bit_idx <= bit_idx + 3'd1;
            if (sample) shreg <= {rxs, shreg[7:1]};
        end
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign do_pop  = rx_pop && !empty;
    // When full, a same-cycle pop frees the slot being written; the old
    // head is consumed this cycle, so overwriting its cell is safe.
    assign push_ok = push_req && (!full || rx_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            rx_interrupt <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            rx_interrupt <= push_ok;
            if (push_ok) begin
                mem[wr_ptr[PTR_W-1:0]] <= shreg;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Set events take priority over a coincident clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (push_req && !push_ok) overrun <= 1'b1;
            else if (clr_err)         overrun <= 1'b0;
            if (frame_set)            frame_err <= 1'b1;
            else if (clr_err)         frame_err <= 1'b0;
        end
    end

    assign rx_data  = mem[rd_ptr[PTR_W-1:0]];
    assign rx_valid = !empty;
    assign rx_count = wr_ptr - rd_ptr;

endmodule
